// File: rtl/dpram_req_scheduler.sv
// -----------------------------------------------------------------------------
// dpram_req_scheduler
//
// Request scheduler in front of a latency-wrapped dual-port RAM. Each port
// takes a valid/ready request stream and drives the RAM port directly
// (combinationally) when the request fires. Writes in flight inside the RAM's
// write-latency pipeline are mirrored in per-port write trackers; any request
// that would observe or overtake such a write is stalled. Per-port read
// trackers produce a valid strobe aligned with the RAM read data.
//
// Ports:
//   clk, rst                      single clock, async active-high reset
//   i_req_valid_x / o_req_ready_x request handshake, port A / B
//   i_req_we_x                    1 = write, 0 = read
//   i_req_addr_x, i_req_data_x    request address / write data
//   o_enx, o_wex, o_addrx, o_dinx RAM port drive (all zero when not firing)
//   i_doutx                       RAM read data
//   o_rvalid_x, o_rdata_x         read data strobe and data
//   o_busy                        any tracked write or read in flight
//
// All latency parameters must be at least 1.
// -----------------------------------------------------------------------------
module dpram_req_scheduler #(
   parameter int DATA_WIDTH  = 8,
   parameter int MEM_DEPTH   = 16,
   parameter int ADDR_WIDTH  = $clog2(MEM_DEPTH),
   parameter int WR_LATENCYA = 1,
   parameter int WR_LATENCYB = 1,
   parameter int RD_LATENCYA = 1,
   parameter int RD_LATENCYB = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req_valid_a,
   output logic                  o_req_ready_a,
   input  logic                  i_req_we_a,
   input  logic [ADDR_WIDTH-1:0] i_req_addr_a,
   input  logic [DATA_WIDTH-1:0] i_req_data_a,
   input  logic                  i_req_valid_b,
   output logic                  o_req_ready_b,
   input  logic                  i_req_we_b,
   input  logic [ADDR_WIDTH-1:0] i_req_addr_b,
   input  logic [DATA_WIDTH-1:0] i_req_data_b,
   output logic                  o_ena,
   output logic                  o_wea,
   output logic [ADDR_WIDTH-1:0] o_addra,
   output logic [DATA_WIDTH-1:0] o_dina,
   output logic                  o_enb,
   output logic                  o_web,
   output logic [ADDR_WIDTH-1:0] o_addrb,
   output logic [DATA_WIDTH-1:0] o_dinb,
   input  logic [DATA_WIDTH-1:0] i_douta,
   input  logic [DATA_WIDTH-1:0] i_doutb,
   output logic                  o_rvalid_a,
   output logic [DATA_WIDTH-1:0] o_rdata_a,
   output logic                  o_rvalid_b,
   output logic [DATA_WIDTH-1:0] o_rdata_b,
   output logic                  o_busy
);

   // Write trackers: {valid, addr} per stage, stage 0 is the newest entry.
   logic [WR_LATENCYA-1:0] r_wv_a;
   logic [ADDR_WIDTH-1:0]  r_wa_a [WR_LATENCYA];
   logic [WR_LATENCYB-1:0] r_wv_b;
   logic [ADDR_WIDTH-1:0]  r_wa_b [WR_LATENCYB];

   // Read trackers: valid only; the last stage lines up with RAM read data.
   logic [RD_LATENCYA-1:0] r_rv_a;
   logic [RD_LATENCYB-1:0] r_rv_b;

   logic w_fire_a;
   logic w_fire_b;
   logic w_stall_a;
   logic w_stall_b;
   logic w_hit_a_trka;   // port-A address vs A write tracker
   logic w_hit_a_trkb;   // port-A address vs B write tracker
   logic w_hit_b_trka;   // port-B address vs A write tracker
   logic w_hit_b_trkb;   // port-B address vs B write tracker
   logic w_a_same_wr;    // port A writing port B's address this cycle

   assign w_fire_a = i_req_valid_a & o_req_ready_a;
   assign w_fire_b = i_req_valid_b & o_req_ready_b;

   // Address match of both request ports against the port-A write tracker.
   always_comb begin
      w_hit_a_trka = 1'b0;
      w_hit_b_trka = 1'b0;
      for (int i = 0; i < WR_LATENCYA; i++) begin
         w_hit_a_trka = w_hit_a_trka | (r_wv_a[i] & (r_wa_a[i] == i_req_addr_a));
         w_hit_b_trka = w_hit_b_trka | (r_wv_a[i] & (r_wa_a[i] == i_req_addr_b));
      end
   end

   // Address match of both request ports against the port-B write tracker.
   always_comb begin
      w_hit_a_trkb = 1'b0;
      w_hit_b_trkb = 1'b0;
      for (int i = 0; i < WR_LATENCYB; i++) begin
         w_hit_a_trkb = w_hit_a_trkb | (r_wv_b[i] & (r_wa_b[i] == i_req_addr_a));
         w_hit_b_trkb = w_hit_b_trkb | (r_wv_b[i] & (r_wa_b[i] == i_req_addr_b));
      end
   end

   // A same-cycle A read with a B write to the same address is allowed: the
   // B write lands later in the pipeline, so A still returns the old word.
   assign w_a_same_wr = w_fire_a & i_req_we_a & (i_req_addr_a == i_req_addr_b);

   // Stall decision per port; port A never looks at port B's same-cycle request.
   always_comb begin
      w_stall_a = 1'b0;
      w_stall_b = 1'b0;
      if (i_req_we_a) begin
         // Own-port writes stay ordered by the RAM's write pipeline.
         w_stall_a = w_hit_a_trkb;
      end else begin
         w_stall_a = w_hit_a_trka | w_hit_a_trkb;
      end
      if (i_req_we_b) begin
         w_stall_b = w_hit_b_trka | w_a_same_wr;
      end else begin
         w_stall_b = w_hit_b_trka | w_hit_b_trkb | w_a_same_wr;
      end
   end

   assign o_req_ready_a = ~rst & ~w_stall_a;
   assign o_req_ready_b = ~rst & ~w_stall_b;

   // RAM port-A drive, zeroed whenever the request does not fire.
   always_comb begin
      if (w_fire_a) begin
         o_ena   = 1'b1;
         o_wea   = i_req_we_a;
         o_addra = i_req_addr_a;
         o_dina  = i_req_data_a;
      end else begin
         o_ena   = 1'b0;
         o_wea   = 1'b0;
         o_addra = '0;
         o_dina  = '0;
      end
   end

   // RAM port-B drive, zeroed whenever the request does not fire.
   always_comb begin
      if (w_fire_b) begin
         o_enb   = 1'b1;
         o_web   = i_req_we_b;
         o_addrb = i_req_addr_b;
         o_dinb  = i_req_data_b;
      end else begin
         o_enb   = 1'b0;
         o_web   = 1'b0;
         o_addrb = '0;
         o_dinb  = '0;
      end
   end

   // Port-A write tracker shift register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wv_a <= '0;
         for (int i = 0; i < WR_LATENCYA; i++) r_wa_a[i] <= '0;
      end else begin
         r_wv_a[0] <= w_fire_a & i_req_we_a;
         r_wa_a[0] <= i_req_addr_a;
         for (int i = 1; i < WR_LATENCYA; i++) begin
            r_wv_a[i] <= r_wv_a[i-1];
            r_wa_a[i] <= r_wa_a[i-1];
         end
      end
   end

   // Port-B write tracker shift register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wv_b <= '0;
         for (int i = 0; i < WR_LATENCYB; i++) r_wa_b[i] <= '0;
      end else begin
         r_wv_b[0] <= w_fire_b & i_req_we_b;
         r_wa_b[0] <= i_req_addr_b;
         for (int i = 1; i < WR_LATENCYB; i++) begin
            r_wv_b[i] <= r_wv_b[i-1];
            r_wa_b[i] <= r_wa_b[i-1];
         end
      end
   end

   // Read-valid trackers for both ports.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rv_a <= '0;
         r_rv_b <= '0;
      end else begin
         r_rv_a[0] <= w_fire_a & ~i_req_we_a;
         r_rv_b[0] <= w_fire_b & ~i_req_we_b;
         for (int i = 1; i < RD_LATENCYA; i++) r_rv_a[i] <= r_rv_a[i-1];
         for (int i = 1; i < RD_LATENCYB; i++) r_rv_b[i] <= r_rv_b[i-1];
      end
   end

   assign o_rvalid_a = r_rv_a[RD_LATENCYA-1];
   assign o_rvalid_b = r_rv_b[RD_LATENCYB-1];
   assign o_rdata_a  = i_douta;
   assign o_rdata_b  = i_doutb;
   assign o_busy     = (|r_wv_a) | (|r_wv_b) | (|r_rv_a) | (|r_rv_b);

endmodule

// File: tb/tb_dpram_req_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dpram_req_scheduler
//
// Directed bench with a behavioural latency-wrapped dual-port RAM. A cycle
// table drives both request ports and holds hand-computed ready / rvalid /
// rdata / busy values; hand-written sequences cover streaming reads and
// reset while reads are outstanding.
// Latencies: WR A=2, WR B=1, RD A=3, RD B=2.
// -----------------------------------------------------------------------------
module tb_dpram_req_scheduler;

   localparam int DW  = 8;
   localparam int AW  = 4;
   localparam int WLA = 2;
   localparam int WLB = 1;
   localparam int RLA = 3;
   localparam int RLB = 2;

   logic          clk;
   logic          rst;
   logic          va, wa, vb, wb;
   logic [AW-1:0] aa, ab;
   logic [DW-1:0] da, db;
   logic          rdy_a, rdy_b;
   logic          ena, wea, enb, web;
   logic [AW-1:0] addra, addrb;
   logic [DW-1:0] dina, dinb, douta, doutb;
   logic          rva, rvb, busy;
   logic [DW-1:0] rda, rdb;

   int total = 0;
   int bad   = 0;

   dpram_req_scheduler #(
      .DATA_WIDTH(DW), .MEM_DEPTH(16), .ADDR_WIDTH(AW),
      .WR_LATENCYA(WLA), .WR_LATENCYB(WLB),
      .RD_LATENCYA(RLA), .RD_LATENCYB(RLB)
   ) dut (
      .clk(clk), .rst(rst),
      .i_req_valid_a(va), .o_req_ready_a(rdy_a), .i_req_we_a(wa),
      .i_req_addr_a(aa), .i_req_data_a(da),
      .i_req_valid_b(vb), .o_req_ready_b(rdy_b), .i_req_we_b(wb),
      .i_req_addr_b(ab), .i_req_data_b(db),
      .o_ena(ena), .o_wea(wea), .o_addra(addra), .o_dina(dina),
      .o_enb(enb), .o_web(web), .o_addrb(addrb), .o_dinb(dinb),
      .i_douta(douta), .i_doutb(doutb),
      .o_rvalid_a(rva), .o_rdata_a(rda),
      .o_rvalid_b(rvb), .o_rdata_b(rdb),
      .o_busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RAM: writes commit WL edges after accept, reads return RL edges later.
   logic [DW-1:0] mem   [16];
   logic          wpa_v [WLA];
   logic [AW-1:0] wpa_a [WLA];
   logic [DW-1:0] wpa_d [WLA];
   logic          wpb_v [WLB];
   logic [AW-1:0] wpb_a [WLB];
   logic [DW-1:0] wpb_d [WLB];
   logic [DW-1:0] rpa   [RLA];
   logic [DW-1:0] rpb   [RLB];

   assign douta = rpa[RLA-1];
   assign doutb = rpb[RLB-1];

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
      for (int i = 0; i < WLA; i++) begin wpa_v[i] = 1'b0; wpa_a[i] = 4'h0; wpa_d[i] = 8'h00; end
      for (int i = 0; i < WLB; i++) begin wpb_v[i] = 1'b0; wpb_a[i] = 4'h0; wpb_d[i] = 8'h00; end
      for (int i = 0; i < RLA; i++) rpa[i] = 8'h00;
      for (int i = 0; i < RLB; i++) rpb[i] = 8'h00;
      forever begin
         @(posedge clk);
         if (wpa_v[WLA-1]) mem[wpa_a[WLA-1]] <= wpa_d[WLA-1];
         if (wpb_v[WLB-1]) mem[wpb_a[WLB-1]] <= wpb_d[WLB-1];
         for (int i = WLA-1; i > 0; i--) begin wpa_v[i] <= wpa_v[i-1]; wpa_a[i] <= wpa_a[i-1]; wpa_d[i] <= wpa_d[i-1]; end
         for (int i = WLB-1; i > 0; i--) begin wpb_v[i] <= wpb_v[i-1]; wpb_a[i] <= wpb_a[i-1]; wpb_d[i] <= wpb_d[i-1]; end
         wpa_v[0] <= ena & wea; wpa_a[0] <= addra; wpa_d[0] <= dina;
         wpb_v[0] <= enb & web; wpb_a[0] <= addrb; wpb_d[0] <= dinb;
         for (int i = RLA-1; i > 0; i--) rpa[i] <= rpa[i-1];
         for (int i = RLB-1; i > 0; i--) rpb[i] <= rpb[i-1];
         if (ena & ~wea) rpa[0] <= mem[addra];
         if (enb & ~web) rpb[0] <= mem[addrb];
      end
   end

   typedef struct {
      logic          va; logic wa; logic [AW-1:0] aa; logic [DW-1:0] da;
      logic          vb; logic wb; logic [AW-1:0] ab; logic [DW-1:0] db;
      logic          rdy_a; logic rdy_b;
      logic          rva; logic [DW-1:0] rda;
      logic          rvb; logic [DW-1:0] rdb;
      logic          busy;
   } vec_t;

   localparam int NV = 31;
   vec_t          vecs [NV];
   logic [DW-1:0] exp_mem [16];

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic iva, input logic iwa, input logic [AW-1:0] iaa, input logic [DW-1:0] ida,
                        input logic ivb, input logic iwb, input logic [AW-1:0] iab, input logic [DW-1:0] idb);
      va = iva; wa = iwa; aa = iaa; da = ida;
      vb = ivb; wb = iwb; ab = iab; db = idb;
   endtask

   initial begin
      logic fa, fb;
      // Cycle table: inputs applied before edge k, expectations seen before edge k.
      //            va    wa    aa    da     vb    wb    ab    db     rdyA  rdyB  rva   rda    rvb   rdb    busy
      vecs[0]  = '{1'b1,1'b1,4'h3,8'h5A, 1'b0,1'b0,4'h0,8'h00, 1'b1,1'b1, 1'b0,8'h00, 1'b0,8'h00, 1'b0};
      vecs[1]  = '{1'b1,1'b0,4'h3,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b0,1'b1, 1'b0,8'h00, 1'b0,8'h00, 1'b1};
      vecs[2]  = '{1'b1,1'b0,4'h3,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b0,1'b1, 1'b0,8'h00, 1'b0,8'h00, 1'b1};
      vecs[3]  = '{1'b1,1'b0,4'h3,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b1,1'b1, 1'b0,8'h00, 1'b0,8'h00, 1'b0};
      vecs[4]  = '{1'b1,1'b0,4'h5,8'h00, 1'b1,1'b0,4'h3,8'h00, 1'b1,1'b1, 1'b0,8'h00, 1'b0,8'h00, 1'b1};
      vecs[5]  = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b1,1'b1, 1'b0,8'h00, 1'b0,8'h00, 1'b1};
      vecs[6]  = '{1'b1,1'b0,4'h4,8'h00, 1'b1,1'b1,4'h4,8'h99, 1'b1,1'b1, 1'b1,8'h5A, 1'b1,8'h5A, 1'b1};
      vecs[7]  = '{1'b1,1'b0,4'h4,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b0,1'b1, 1'b1,8'hA5, 1'b0,8'h00, 1'b1};
      vecs[8]  = '{1'b1,1'b0,4'h4,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b1,1'b1, 1'b0,8'h00, 1'b0,8'h00, 1'b1};
      vecs[9]  = '{1'b1,1'b1,4'h7,8'h11, 1'b1,1'b1,4'h7,8'h22, 1'b1,1'b0, 1'b1,8'hA4, 1'b0,8'h00, 1'b1};
      vecs[10] = '{1'b0,1'b0,4'h0,8'h00, 1'b1,1'b1,4'h7,8'h22, 1'b1,1'b0, 1'b0,8'h00, 1'b0,8'h00, 1'b1};
      vecs[11] = '{1'b0,1'b0,4'h0,8'h00, 1'b1,1'b1,4'h7,8'h22, 1'b1,1'b0, 1'b1,8'h99, 1'b0,8'h00, 1'b1};
      vecs[12] = '{1'b0,1'b0,4'h0,8'h00, 1'b1,1'b1,4'h7,8'h22, 1'b1,1'b1, 1'b0,8'h00, 1'b0,8'h00, 1'b0};
      vecs[13] = '{1'b1,1'b0,4'h7,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b0,1'b1, 1'b0,8'h00, 1'b0,8'h00, 1'b1};
      vecs[14] = '{1'b1,1'b0,4'h7,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b1,1'b1, 1'b0,8'h00, 1'b0,8'h00, 1'b0};
      vecs[15] = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b1,1'b1, 1'b0,8'h00, 1'b0,8'h00, 1'b1};
      vecs[16] = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b1,1'b1, 1'b0,8'h00, 1'b0,8'h00, 1'b1};
      vecs[17] = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b1,1'b1, 1'b1,8'h22, 1'b0,8'h00, 1'b1};
      vecs[18] = '{1'b1,1'b1,4'h2,8'h01, 1'b0,1'b0,4'h0,8'h00, 1'b1,1'b1, 1'b0,8'h00, 1'b0,8'h00, 1'b0};
      vecs[19] = '{1'b0,1'b0,4'h0,8'h00, 1'b1,1'b1,4'h2,8'h02, 1'b1,1'b0, 1'b0,8'h00, 1'b0,8'h00, 1'b1};
      vecs[20] = '{1'b0,1'b0,4'h0,8'h00, 1'b1,1'b1,4'h2,8'h02, 1'b1,1'b0, 1'b0,8'h00, 1'b0,8'h00, 1'b1};
      vecs[21] = '{1'b0,1'b0,4'h0,8'h00, 1'b1,1'b1,4'h2,8'h02, 1'b1,1'b1, 1'b0,8'h00, 1'b0,8'h00, 1'b0};
      vecs[22] = '{1'b1,1'b0,4'h2,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b0,1'b1, 1'b0,8'h00, 1'b0,8'h00, 1'b1};
      vecs[23] = '{1'b1,1'b0,4'h2,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b1,1'b1, 1'b0,8'h00, 1'b0,8'h00, 1'b0};
      vecs[24] = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b1,1'b1, 1'b0,8'h00, 1'b0,8'h00, 1'b1};
      vecs[25] = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b1,1'b1, 1'b0,8'h00, 1'b0,8'h00, 1'b1};
      vecs[26] = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b1,1'b1, 1'b1,8'h02, 1'b0,8'h00, 1'b1};
      vecs[27] = '{1'b1,1'b1,4'h9,8'h33, 1'b1,1'b0,4'h9,8'h00, 1'b1,1'b0, 1'b0,8'h00, 1'b0,8'h00, 1'b0};
      vecs[28] = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b1,1'b1, 1'b0,8'h00, 1'b0,8'h00, 1'b1};
      vecs[29] = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b1,1'b1, 1'b0,8'h00, 1'b0,8'h00, 1'b1};
      vecs[30] = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b1,1'b1, 1'b0,8'h00, 1'b0,8'h00, 1'b0};

      // Memory contents expected once the table has run.
      for (int i = 0; i < 16; i++) exp_mem[i] = 8'hA0 + 8'(i);
      exp_mem[2] = 8'h02; exp_mem[3] = 8'h5A; exp_mem[4] = 8'h99;
      exp_mem[7] = 8'h22; exp_mem[9] = 8'h33;

      // Reset state, with a request presented to prove the RAM drive stays quiet.
      rst = 1'b1;
      drive(1'b1, 1'b0, 4'h1, 8'h00, 1'b1, 1'b1, 4'h2, 8'h77);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_rdy_a", {7'd0, rdy_a}, 8'h00);
      chk("rst_rdy_b", {7'd0, rdy_b}, 8'h00);
      chk("rst_ena",   {7'd0, ena},   8'h00);
      chk("rst_enb",   {7'd0, enb},   8'h00);
      chk("rst_dinb",  dinb,          8'h00);
      chk("rst_rva",   {7'd0, rva},   8'h00);
      chk("rst_busy",  {7'd0, busy},  8'h00);
      @(posedge clk);
      #1 rst = 1'b0;

      // Table-driven main sequence.
      for (int k = 0; k < NV; k++) begin
         drive(vecs[k].va, vecs[k].wa, vecs[k].aa, vecs[k].da, vecs[k].vb, vecs[k].wb, vecs[k].ab, vecs[k].db);
         @(negedge clk);
         fa = vecs[k].va & vecs[k].rdy_a;
         fb = vecs[k].vb & vecs[k].rdy_b;
         chk($sformatf("v%0d_rdy_a", k), {7'd0, rdy_a}, {7'd0, vecs[k].rdy_a});
         chk($sformatf("v%0d_rdy_b", k), {7'd0, rdy_b}, {7'd0, vecs[k].rdy_b});
         chk($sformatf("v%0d_ena", k),   {7'd0, ena},   {7'd0, fa});
         chk($sformatf("v%0d_wea", k),   {7'd0, wea},   {7'd0, fa & vecs[k].wa});
         chk($sformatf("v%0d_addra", k), {4'd0, addra}, fa ? {4'd0, vecs[k].aa} : 8'h00);
         chk($sformatf("v%0d_dina", k),  dina,          fa ? vecs[k].da : 8'h00);
         chk($sformatf("v%0d_enb", k),   {7'd0, enb},   {7'd0, fb});
         chk($sformatf("v%0d_web", k),   {7'd0, web},   {7'd0, fb & vecs[k].wb});
         chk($sformatf("v%0d_addrb", k), {4'd0, addrb}, fb ? {4'd0, vecs[k].ab} : 8'h00);
         chk($sformatf("v%0d_dinb", k),  dinb,          fb ? vecs[k].db : 8'h00);
         chk($sformatf("v%0d_rva", k),   {7'd0, rva},   {7'd0, vecs[k].rva});
         chk($sformatf("v%0d_rvb", k),   {7'd0, rvb},   {7'd0, vecs[k].rvb});
         chk($sformatf("v%0d_busy", k),  {7'd0, busy},  {7'd0, vecs[k].busy});
         if (vecs[k].rva) chk($sformatf("v%0d_rda", k), rda, vecs[k].rda);
         if (vecs[k].rvb) chk($sformatf("v%0d_rdb", k), rdb, vecs[k].rdb);
         @(posedge clk);
         #1;
      end

      // Streaming reads of every address on port A: one rvalid per cycle, RLA later.
      for (int i = 0; i < 20; i++) begin
         if (i < 16) drive(1'b1, 1'b0, 4'(i), 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
         else        drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
         @(negedge clk);
         if (i < 16) chk($sformatf("str%0d_rdy", i), {7'd0, rdy_a}, 8'h01);
         chk($sformatf("str%0d_rva", i), {7'd0, rva}, (i >= RLA && i < 16 + RLA) ? 8'h01 : 8'h00);
         if (i >= RLA && i < 16 + RLA) chk($sformatf("str%0d_rda", i), rda, exp_mem[i-RLA]);
         @(posedge clk);
         #1;
      end

      // Reset with reads outstanding on both ports.
      drive(1'b1, 1'b0, 4'h5, 8'h00, 1'b1, 1'b0, 4'h8, 8'h00);
      @(posedge clk);
      #1 drive(1'b1, 1'b0, 4'h6, 8'h00, 1'b1, 1'b0, 4'hA, 8'h00);
      @(posedge clk);
      #1 drive(1'b1, 1'b0, 4'h1, 8'h00, 1'b1, 1'b1, 4'hB, 8'h44);
      chk("pre_rst_busy", {7'd0, busy}, 8'h01);
      rst = 1'b1;
      #1;
      chk("mid_rst_rva",   {7'd0, rva},   8'h00);
      chk("mid_rst_rvb",   {7'd0, rvb},   8'h00);
      chk("mid_rst_busy",  {7'd0, busy},  8'h00);
      chk("mid_rst_rdy_a", {7'd0, rdy_a}, 8'h00);
      chk("mid_rst_rdy_b", {7'd0, rdy_b}, 8'h00);
      chk("mid_rst_ena",   {7'd0, ena},   8'h00);
      chk("mid_rst_web",   {7'd0, web},   8'h00);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_rdy_a", {7'd0, rdy_a}, 8'h01);
      chk("post_rst_rdy_b", {7'd0, rdy_b}, 8'h01);
      chk("post_rst_busy",  {7'd0, busy},  8'h00);
      @(posedge clk);
      #1 drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk($sformatf("post_rst%0d_rva", k), {7'd0, rva}, (k == RLA) ? 8'h01 : 8'h00);
         chk($sformatf("post_rst%0d_rvb", k), {7'd0, rvb}, 8'h00);
         if (k == RLA) chk("post_rst_rda", rda, 8'hA1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
